acc_alu_sequencer: RTL and testbench



---
 rtl/acc_alu_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_acc_alu_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_sequencer.sv
// acc_alu_sequencer: one-op-at-a-time control sequencer for the 8-bit
// accumulator/ALU datapath (reg A, reg B, add/sub ALU, shared bus).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_ready        operation handshake (accept when both high)
//   opcode[2:0], operand     operation and immediate, sampled on accept
//   cf_in, zf_in             ALU flags, captured at the end of ADD/SUB
//   la_n, lb_n               active-low load strobes for A and B
//   ea, eu, imm_en           bus drivers: reg A, ALU result, immediate
//   sub                      ALU subtract select
//   imm_data                 immediate bus value (zero when imm_en=0)
//   out_strobe               bus holds reg A for external capture
//   cf_q, zf_q               latched flags
//   done, err                completion pulse, illegal-opcode pulse
//   op_count                 completed-operation counter (wraps)
module acc_alu_sequencer #(
    parameter int WIDTH    = 8,
    parameter int OUT_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    input  logic             cf_in,
    input  logic             zf_in,
    output logic             la_n,
    output logic             lb_n,
    output logic             ea,
    output logic             eu,
    output logic             sub,
    output logic             imm_en,
    output logic [WIDTH-1:0] imm_data,
    output logic             out_strobe,
    output logic             cf_q,
    output logic             zf_q,
    output logic             done,
    output logic             err,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_OUT = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // EXEC covers the first OUT cycle; HOLD covers the remaining OUT_HOLD-1.
    localparam logic [3:0] HOLD_INIT =
        (OUT_HOLD > 1) ? 4'(OUT_HOLD - 2) : 4'd0;

    state_t           r_state, w_state_nx;
    logic [2:0]       r_op;
    logic [3:0]       r_hold, w_hold_nx;
    logic             r_la_n, r_lb_n, r_ea, r_eu, r_sub, r_imm_en;
    logic             r_out, r_done, r_err, r_cf, r_zf;
    logic [WIDTH-1:0] r_imm;
    logic [7:0]       r_count;

    logic             w_la_n, w_lb_n, w_ea, w_eu, w_sub, w_imm_en;
    logic             w_out, w_done, w_err, w_accept;
    logic [WIDTH-1:0] w_imm;

    assign op_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = op_valid && op_ready;

    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_la_n     = 1'b1;
        w_lb_n     = 1'b1;
        w_ea       = 1'b0;
        w_eu       = 1'b0;
        w_sub      = 1'b0;
        w_imm_en   = 1'b0;
        w_imm      = '0;
        w_out      = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Decode on accept so EXEC strobes are registered.
                if (w_accept) begin
                    w_state_nx = S_EXEC;
                    case (opcode)
                        OP_LDA: begin
                            w_imm_en = 1'b1;
                            w_imm    = operand;
                            w_la_n   = 1'b0;
                        end
                        OP_LDB: begin
                            w_imm_en = 1'b1;
                            w_imm    = operand;
                            w_lb_n   = 1'b0;
                        end
                        OP_ADD: begin
                            w_eu   = 1'b1;
                            w_la_n = 1'b0;
                        end
                        OP_SUB: begin
                            w_eu   = 1'b1;
                            w_sub  = 1'b1;
                            w_la_n = 1'b0;
                        end
                        OP_OUT: begin
                            w_ea  = 1'b1;
                            w_out = 1'b1;
                        end
                        OP_CLR: begin
                            w_imm_en = 1'b1;
                            w_la_n   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC: begin
                if (r_op == OP_OUT && OUT_HOLD > 1) begin
                    w_state_nx = S_HOLD;
                    w_hold_nx  = HOLD_INIT;
                    w_ea       = 1'b1;
                    w_out      = 1'b1;
                end else begin
                    w_state_nx = S_DONE;
                    w_done     = 1'b1;
                    w_err      = (r_op == OP_ILL);
                end
            end
            S_HOLD: begin
                if (r_hold == 4'd0) begin
                    w_state_nx = S_DONE;
                    w_done     = 1'b1;
                end else begin
                    w_hold_nx = r_hold - 4'd1;
                    w_ea      = 1'b1;
                    w_out     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NOP;
            r_hold   <= 4'd0;
            r_la_n   <= 1'b1;
            r_lb_n   <= 1'b1;
            r_ea     <= 1'b0;
            r_eu     <= 1'b0;
            r_sub    <= 1'b0;
            r_imm_en <= 1'b0;
            r_imm    <= '0;
            r_out    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            r_state  <= w_state_nx;
            r_hold   <= w_hold_nx;
            r_la_n   <= w_la_n;
            r_lb_n   <= w_lb_n;
            r_ea     <= w_ea;
            r_eu     <= w_eu;
            r_sub    <= w_sub;
            r_imm_en <= w_imm_en;
            r_imm    <= w_imm;
            r_out    <= w_out;
            r_done   <= w_done;
            r_err    <= w_err;
            if (w_accept) begin
                r_op <= opcode;
            end
            // ALU result is on the bus during EXEC; grab its flags then.
            if (r_state == S_EXEC &&
                (r_op == OP_ADD || r_op == OP_SUB)) begin
                r_cf <= cf_in;
                r_zf <= zf_in;
            end
            if (w_done) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign la_n       = r_la_n;
    assign lb_n       = r_lb_n;
    assign ea         = r_ea;
    assign eu         = r_eu;
    assign sub        = r_sub;
    assign imm_en     = r_imm_en;
    assign imm_data   = r_imm;
    assign out_strobe = r_out;
    assign cf_q       = r_cf;
    assign zf_q       = r_zf;
    assign done       = r_done;
    assign err        = r_err;
    assign op_count   = r_count;

endmodule

// File: tb/tb_acc_alu_sequencer.sv
// Testbench for acc_alu_sequencer: drives random and directed ops into
// an OUT_HOLD=1 and an OUT_HOLD=4 instance against a behavioural model.
module tb_acc_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [2:0] opcode;
    logic [7:0] operand;
    logic       sel;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 1 (OUT_HOLD=1) and DUT 2 (OUT_HOLD=4) outputs
    logic       rdy1, la1, lb1, ea1, eu1, sb1, ie1, os1;
    logic       cf1, zf1, dn1, er1;
    logic [7:0] im1, cnt1;
    logic       rdy2, la2, lb2, ea2, eu2, sb2, ie2, os2;
    logic       cf2, zf2, dn2, er2;
    logic [7:0] im2, cnt2;

    // datapath around DUT 1: registers A/B, adder/subtractor, bus
    logic [7:0] env_a, env_b, bus;
    logic [8:0] alu9;
    logic       cf_in, zf_in;

    always_comb begin
        alu9 = sb1 ? ({1'b0, env_a} - {1'b0, env_b})
                   : ({1'b0, env_a} + {1'b0, env_b});
        cf_in = alu9[8];
        zf_in = (alu9[7:0] == 8'd0);
        bus = 8'd0;
        if (ie1) bus = im1;
        else if (eu1) bus = alu9[7:0];
        else if (ea1) bus = env_a;
    end

    always @(posedge clk) begin
        if (rst) begin
            env_a <= 8'd0;
            env_b <= 8'd0;
        end else begin
            if (!la1) env_a <= bus;
            if (!lb1) env_b <= bus;
        end
    end

    acc_alu_sequencer #(.WIDTH(8), .OUT_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .op_valid(op_valid & ~sel), .op_ready(rdy1),
        .opcode(opcode), .operand(operand),
        .cf_in(cf_in), .zf_in(zf_in),
        .la_n(la1), .lb_n(lb1), .ea(ea1), .eu(eu1), .sub(sb1),
        .imm_en(ie1), .imm_data(im1), .out_strobe(os1),
        .cf_q(cf1), .zf_q(zf1), .done(dn1), .err(er1),
        .op_count(cnt1)
    );

    acc_alu_sequencer #(.WIDTH(8), .OUT_HOLD(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .op_valid(op_valid & sel), .op_ready(rdy2),
        .opcode(opcode), .operand(operand),
        .cf_in(cf_in), .zf_in(zf_in),
        .la_n(la2), .lb_n(lb2), .ea(ea2), .eu(eu2), .sub(sb2),
        .imm_en(ie2), .imm_data(im2), .out_strobe(os2),
        .cf_q(cf2), .zf_q(zf2), .done(dn2), .err(er2),
        .op_count(cnt2)
    );

    // selected-DUT views
    logic [14:0] g_vec, vec1, vec2;
    logic        g_ready, g_done, g_err, g_ea, g_os;
    logic [7:0]  g_cnt;
    assign vec1 = {la1, lb1, ea1, eu1, sb1, ie1, os1, im1};
    assign vec2 = {la2, lb2, ea2, eu2, sb2, ie2, os2, im2};
    assign g_vec   = sel ? vec2 : vec1;
    assign g_ready = sel ? rdy2 : rdy1;
    assign g_done  = sel ? dn2  : dn1;
    assign g_err   = sel ? er2  : er1;
    assign g_ea    = sel ? ea2  : ea1;
    assign g_os    = sel ? os2  : os1;
    assign g_cnt   = sel ? cnt2 : cnt1;

    // reference model state
    logic [7:0] ref_a, ref_b;
    logic       ref_cf, ref_zf;
    logic [7:0] ref_cnt [2];

    localparam logic [14:0] IDLE_VEC = {7'b1100000, 8'h00};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] exp_exec(input logic [2:0] op,
                                             input logic [7:0] v);
        case (op)
            3'd1:    return {7'b0100010, v};
            3'd2:    return {7'b1000010, v};
            3'd3:    return {7'b0101000, 8'h00};
            3'd4:    return {7'b0101100, 8'h00};
            3'd5:    return {7'b1110001, 8'h00};
            3'd6:    return {7'b0100010, 8'h00};
            default: return IDLE_VEC;
        endcase
    endfunction

    function automatic logic inv_ok(input logic [14:0] v);
        int drv;
        drv = int'(v[12]) + int'(v[11]) + int'(v[9]);
        return (drv <= 1) && (v[14] || v[13]) && (!v[10] || v[11])
            && (v[9] || v[7:0] == 8'h00);
    endfunction

    task automatic model(input logic [2:0] op, input logic [7:0] v);
        logic [8:0] s;
        if (!sel) begin
            case (op)
                3'd1: ref_a = v;
                3'd2: ref_b = v;
                3'd3: begin
                    s = 9'(ref_a) + 9'(ref_b);
                    ref_cf = s[8];
                    ref_a = s[7:0];
                    ref_zf = (ref_a == 8'd0);
                end
                3'd4: begin
                    ref_cf = (ref_a < ref_b);
                    ref_a = ref_a - ref_b;
                    ref_zf = (ref_a == 8'd0);
                end
                3'd6: ref_a = 8'd0;
                default: ;
            endcase
        end
        ref_cnt[sel] = ref_cnt[sel] + 8'd1;
    endtask

    task automatic model_reset();
        ref_a = 0; ref_b = 0; ref_cf = 0; ref_zf = 0;
        ref_cnt[0] = 0; ref_cnt[1] = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!g_ready && n < 50) begin
            step();
            n++;
        end
        chk("ready", g_ready, 1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] v);
        int hold;
        hold = sel ? 4 : 1;
        wait_ready();
        opcode = op; operand = v; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        opcode = 3'($urandom); operand = 8'($urandom);
        chk("exec", g_vec, exp_exec(op, v));
        chk("exec_busy", {g_ready, g_done}, 0);
        if (op == 3'd5) begin
            for (int i = 1; i < hold; i++) begin
                step();
                chk("hold", {g_ea, g_os, g_done}, 3'b110);
            end
        end
        model(op, v);
        step();
        chk("done", {g_done, g_err}, {1'b1, op == 3'd7});
        chk("done_idle", g_vec, IDLE_VEC);
        step();
        chk("post_done", g_done, 0);
        chk("post_ready", g_ready, 1);
        chk("count", g_cnt, ref_cnt[sel]);
        if (!sel) begin
            chk("flags", {cf1, zf1}, {ref_cf, ref_zf});
            chk("reg_a", env_a, ref_a);
            chk("reg_b", env_b, ref_b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("inv1", inv_ok(vec1), 1);
            chk("inv2", inv_ok(vec2), 1);
        end
    end

    initial begin
        int acc_q[$];
        int done_q[$];
        int n;
        logic [2:0] bops[4];
        logic [7:0] bvals[4];

        rst = 1; op_valid = 0; opcode = 0; operand = 0; sel = 0;
        model_reset();
        step();
        step();
        chk("rst_vec1", vec1, IDLE_VEC);
        chk("rst_vec2", vec2, IDLE_VEC);
        chk("rst_misc", {rdy1, cf1, zf1, dn1, er1, cnt1}, 0);
        rst = 0;
        #1;
        chk("rst_ready", rdy1, 1);

        // carry + zero, then borrow, then flags untouched by LDA
        run_op(3'd1, 8'h80);
        run_op(3'd2, 8'h80);
        run_op(3'd3, 8'h00);
        chk("add80_flags", {cf1, zf1}, 2'b11);
        run_op(3'd1, 8'h03);
        run_op(3'd2, 8'h05);
        run_op(3'd4, 8'h00);
        chk("sub_a", env_a, 8'hFE);
        run_op(3'd1, 8'h42);
        chk("lda_flags", {cf1, zf1}, {ref_cf, ref_zf});

        // reset during ADD EXEC
        opcode = 3'd3; op_valid = 1;
        step();
        op_valid = 0;
        chk("rst_pre_la", {la1, eu1}, 2'b01);
        rst = 1;
        step();
        chk("rst_mid", {la1, eu1, cf1, zf1, dn1, rdy1}, 6'b100000);
        chk("rst_mid_cnt", cnt1, 0);
        step();
        rst = 0;
        model_reset();
        #1;
        chk("rst_rel_ready", rdy1, 1);
        chk("rst_rel_done", dn1, 0);
        step();
        chk("rst_no_done", dn1, 0);

        run_op(3'd1, 8'h05);
        run_op(3'd2, 8'h03);
        run_op(3'd3, 8'h00);
        chk("add_a", env_a, 8'h08);
        run_op(3'd5, 8'h00);
        chk("count4", cnt1, 8'd4);
        run_op(3'd7, 8'hAA);
        run_op(3'd6, 8'h77);

        // back-to-back with op_valid held high
        for (int i = 0; i < 4; i++) bvals[i] = 8'($urandom);
        bops[0] = 3'd1; bops[1] = 3'd2; bops[2] = 3'd3; bops[3] = 3'd4;
        n = 0;
        op_valid = 1;
        for (int c = 0; c < 20; c++) begin
            if (dn1) done_q.push_back(cyc);
            if (n < 4 && rdy1) begin
                opcode = bops[n]; operand = bvals[n];
                acc_q.push_back(cyc);
                model(bops[n], bvals[n]);
                n++;
            end else begin
                opcode = 3'($urandom); operand = 8'($urandom);
                if (n == 4 && rdy1) op_valid = 0;
            end
            step();
        end
        op_valid = 0;
        chk("b2b_acc", acc_q.size(), 4);
        chk("b2b_done", done_q.size(), 4);
        for (int i = 0; i < 3 && i + 1 < acc_q.size(); i++)
            chk("b2b_gap", acc_q[i+1] - acc_q[i], 3);
        for (int i = 0; i < done_q.size() && i < acc_q.size(); i++)
            chk("b2b_lat", done_q[i] - acc_q[i], 2);
        chk("b2b_a", env_a, ref_a);
        chk("b2b_flags", {cf1, zf1}, {ref_cf, ref_zf});
        chk("b2b_cnt", cnt1, ref_cnt[0]);

        for (int i = 0; i < 30; i++)
            run_op(3'($urandom_range(0, 7)), 8'($urandom));

        // OUT_HOLD=4 instance: wrap counter, then long OUT
        sel = 1;
        for (int i = 0; i < 256; i++) run_op(3'd0, 8'($urandom));
        chk("wrap", cnt2, 8'd0);
        run_op(3'd5, 8'h00);
        run_op(3'd7, 8'h00);
        chk("cnt2", cnt2, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
